// File: rtl/enc_pkg.sv
// Shared constants and FSM state encoding for the pending request encoder.
package enc_pkg;
  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 encoder: index of the highest set bit, plus a nonzero flag.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [N-1:0] d,
  output logic [W-1:0] idx,
  output logic         any
);
  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (d[i]) idx = W'(i);
  end

  assign any = |d;
endmodule

// File: rtl/pending_encoder.sv
// Latches request pulses into a pending register and offers the highest pending
// index over a valid/ready handshake, clearing it on acceptance.
module pending_encoder
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [W-1:0] z,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         ovf
);
  state_t state, state_nx;

  logic [N-1:0] set, clr;
  logic [W-1:0] hi_idx;
  logic         hi_any;
  logic         grant;

  prio_enc8 u_enc (
    .d   (pending),
    .idx (hi_idx),
    .any (hi_any)
  );

  assign valid = (state == OFFER);
  assign grant = valid && ready;
  assign set   = en ? x : '0;
  assign clr   = grant ? (N'(1) << z) : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hi_any) state_nx = OFFER;
      OFFER:   if (ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Set wins over clear on the same bit, so a re-request during accept is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      z       <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= (pending & ~clr) | set;
      if (|(set & pending & ~clr)) ovf <= 1'b1;
      // z is latched only when leaving IDLE; held without preemption in OFFER.
      if (state == IDLE && hi_any) z <= hi_idx;
    end
  end
endmodule

// File: tb/tb_pending_encoder.sv
// Directed vector bench for pending_encoder: table rows plus hand-written corner sequences.
module tb_pending_encoder;
  logic       clk = 1'b0;
  logic       rst, en, ready, valid, ovf;
  logic [7:0] x, pending;
  logic [2:0] z;

  int total = 0;
  int bad   = 0;

  pending_encoder dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .z(z),
    .valid(valid), .ready(ready), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       rst;
    logic       en;
    logic [7:0] x;
    logic       ready;
    logic [7:0] ep;
    logic       ev;
    logic [2:0] ez;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic e, input logic [7:0] xi,
                     input logic rd, input logic [7:0] ep, input logic ev,
                     input logic [2:0] ez, input logic eo);
    vec_t v;
    v.nm = nm; v.rst = r; v.en = e; v.x = xi; v.ready = rd;
    v.ep = ep; v.ev = ev; v.ez = ez; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic row(input string nm, input logic r, input logic e, input logic [7:0] xi,
                     input logic rd, input logic [7:0] ep, input logic ev,
                     input logic [2:0] ez, input logic eo);
    rst = r; en = e; x = xi; ready = rd;
    @(posedge clk);
    #1;
    check({nm, ".pending"}, pending, ep);
    check({nm, ".valid"}, {7'b0, valid}, {7'b0, ev});
    if (ev) check({nm, ".z"}, {5'b0, z}, {5'b0, ez});
    check({nm, ".ovf"}, {7'b0, ovf}, {7'b0, eo});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = '0; ready = 1'b0;

    add("rst0", 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("rst1", 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++) add("idle", 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    // single request on bit 5
    add("single_set",   0, 1, 8'h20, 0, 8'h20, 0, 0, 0);
    add("single_offer", 0, 1, 8'h00, 0, 8'h20, 1, 5, 0);
    add("single_acc",   0, 1, 8'h00, 1, 8'h00, 0, 0, 0);
    add("single_quiet", 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    // priority, no preemption, three grants 3 -> 7 -> 0
    add("prio_set",    0, 1, 8'h09, 0, 8'h09, 0, 0, 0);
    add("prio_off3",   0, 1, 8'h00, 0, 8'h09, 1, 3, 0);
    add("prio_hold3a", 0, 1, 8'h80, 0, 8'h89, 1, 3, 0);
    add("prio_hold3b", 0, 1, 8'h00, 0, 8'h89, 1, 3, 0);
    add("prio_acc3",   0, 1, 8'h00, 1, 8'h81, 0, 0, 0);
    add("prio_off7",   0, 1, 8'h00, 0, 8'h81, 1, 7, 0);
    add("prio_acc7",   0, 1, 8'h00, 1, 8'h01, 0, 0, 0);
    add("prio_off0",   0, 1, 8'h00, 0, 8'h01, 1, 0, 0);
    add("prio_acc0",   0, 1, 8'h00, 1, 8'h00, 0, 0, 0);
    add("prio_done",   0, 1, 8'h00, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i])
      row(vecs[i].nm, vecs[i].rst, vecs[i].en, vecs[i].x, vecs[i].ready,
          vecs[i].ep, vecs[i].ev, vecs[i].ez, vecs[i].eo);

    // set and clear of bit 2 on the same edge: set wins, no overflow
    row("sc_set",    0, 1, 8'h04, 0, 8'h04, 0, 0, 0);
    row("sc_off",    0, 1, 8'h00, 0, 8'h04, 1, 2, 0);
    row("sc_both",   0, 1, 8'h04, 1, 8'h04, 0, 0, 0);
    row("sc_reoff",  0, 1, 8'h00, 0, 8'h04, 1, 2, 0);
    row("sc_acc",    0, 1, 8'h00, 1, 8'h00, 0, 0, 0);

    // re-request while pending and not accepted: sticky overflow
    row("ov_set",    0, 1, 8'h04, 0, 8'h04, 0, 0, 0);
    row("ov_off",    0, 1, 8'h00, 0, 8'h04, 1, 2, 0);
    row("ov_hit",    0, 1, 8'h04, 0, 8'h04, 1, 2, 1);
    row("ov_acc",    0, 1, 8'h00, 1, 8'h00, 0, 0, 1);
    row("ov_sticky", 0, 1, 8'h00, 0, 8'h00, 0, 0, 1);
    row("ov_rst",    1, 1, 8'h00, 0, 8'h00, 0, 0, 0);

    // enable gating, then draining a preloaded request with en low
    row("en_gate0",  0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
    row("en_gate1",  0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
    row("en_pre",    0, 1, 8'h01, 0, 8'h01, 0, 0, 0);
    row("en_off0",   0, 0, 8'hFF, 0, 8'h01, 1, 0, 0);
    row("en_acc0",   0, 0, 8'hFF, 1, 8'h00, 0, 0, 0);
    row("en_quiet",  0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);

    // reset during an accepted offer wipes everything
    row("mr_set",    0, 1, 8'h43, 0, 8'h43, 0, 0, 0);
    row("mr_off6",   0, 1, 8'h00, 0, 8'h43, 1, 6, 0);
    row("mr_rst",    1, 1, 8'h00, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) row("mr_quiet", 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
    row("mr_new",    0, 1, 8'h02, 0, 8'h02, 0, 0, 0);
    row("mr_off1",   0, 1, 8'h00, 0, 8'h02, 1, 1, 0);
    row("mr_acc1",   0, 1, 8'h00, 1, 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
